mopshub_test_sequencer: RTL and testbench

- Synthesizable, parametrised successor to the bench-side test-phase control for the MOPSHUB multi-bus system.
- Steps a MOPSHUB stimulus environment through its phases: oscillator trim, sign-on wait, per-bus RX test, end-wait pulse, inter-phase gap, looped TX test and optional advanced test.
- Generalised over bus count, gap length, TX loop count and a per-phase watchdog.
- Sits between the top-level bench/control logic and the test environment's test_* handshake ports.

---
 rtl/mopshub_test_sequencer_if.sv | 40 ++++
 rtl/mopshub_test_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_mopshub_test_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mopshub_test_sequencer_if.sv
// Handshake bundle between MOPSHUB control logic and the test-phase sequencer.
// master: the sequencer; slave: the bench/control side that drives run inputs and *_end pulses.
interface mopshub_test_sequencer_if #(
    parameter int BUS_W  = 5,
    parameter int LOOP_W = 8
);
    logic              start;
    logic              trim_en;
    logic              adv_en;
    logic [BUS_W-1:0]  n_buses;
    logic [LOOP_W-1:0] tx_loop_count;
    logic              end_power_init;
    logic              sign_on_sig;
    logic              test_rx_end;
    logic              test_tx_end;
    logic              test_advanced_end;
    logic              osc_auto_trim;
    logic              test_rx;
    logic              test_tx;
    logic              test_advanced;
    logic              endwait_all;
    logic [BUS_W-1:0]  bus_sel;
    logic [3:0]        phase;
    logic              done;
    logic              err_timeout;

    modport master (
        input  start, trim_en, adv_en, n_buses, tx_loop_count,
        input  end_power_init, sign_on_sig, test_rx_end, test_tx_end, test_advanced_end,
        output osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all,
        output bus_sel, phase, done, err_timeout
    );

    modport slave (
        output start, trim_en, adv_en, n_buses, tx_loop_count,
        output end_power_init, sign_on_sig, test_rx_end, test_tx_end, test_advanced_end,
        input  osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all,
        input  bus_sel, phase, done, err_timeout
    );
endinterface

// File: rtl/mopshub_test_sequencer.sv
// MOPSHUB test-phase sequencer: trim, sign-on, per-bus RX, end-wait, gap, looped TX, advanced test.
// Define MOPSHUB_SEQ_STATS_EN to add saturating rx/tx completion and timeout counters.
module mopshub_test_sequencer #(
    parameter int N_BUS       = 16,
    parameter int BUS_W       = 5,
    parameter int GAP_CYC     = 120,
    parameter int LOOP_W      = 8,
    parameter int TIMEOUT_CYC = 4000000
) (
    input  logic clk_40_m,
    input  logic rst,
`ifdef MOPSHUB_SEQ_STATS_EN
    output logic [15:0] rx_done_cnt,
    output logic [15:0] tx_done_cnt,
    output logic [7:0]  timeout_cnt,
`endif
    mopshub_test_sequencer_if.master sq
);
    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_TRIM        = 4'd1,
        S_WAIT_SIGNON = 4'd2,
        S_RX_RUN      = 4'd3,
        S_ENDWAIT     = 4'd4,
        S_GAP         = 4'd5,
        S_TX_RUN      = 4'd6,
        S_ADV_RUN     = 4'd7,
        S_DONE        = 4'd8,
        S_ERR         = 4'd9
    } state_t;

    // One timer serves both the watchdog and the gap count; it only ever reaches limit-1.
    localparam int TMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
    localparam logic [TW-1:0]     TO_LAST  = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [TW-1:0]     GAP_LAST = TW'(GAP_CYC - 1);
    localparam logic [BUS_W:0]    N_BUS_X  = (BUS_W + 1)'(N_BUS);
    localparam logic [LOOP_W-1:0] LOOP_MAX = '1;

    state_t            state;
    logic [TW-1:0]     timer;
    logic [BUS_W-1:0]  last_bus;
    logic [LOOP_W-1:0] loops;
    logic [LOOP_W-1:0] loop_cnt;
    logic [LOOP_W-1:0] loop_next;
    logic [BUS_W:0]    nb_clamp;
    logic              evt;
    logic              wd_state;
    logic              wd_hit;
    logic              to_err;

    always_comb begin
        nb_clamp = {1'b0, sq.n_buses};
        if (nb_clamp == '0)
            nb_clamp = {{BUS_W{1'b0}}, 1'b1};
        else if (nb_clamp > N_BUS_X)
            nb_clamp = N_BUS_X;
    end

    // Completion event that belongs to the current phase; anything else is spurious.
    always_comb begin
        evt      = 1'b0;
        wd_state = 1'b1;
        case (state)
            S_TRIM:        evt = sq.end_power_init;
            S_WAIT_SIGNON: evt = sq.sign_on_sig;
            S_RX_RUN:      evt = sq.test_rx_end;
            S_TX_RUN:      evt = sq.test_tx_end;
            S_ADV_RUN:     evt = sq.test_advanced_end;
            default:       wd_state = 1'b0;
        endcase
    end

    assign wd_hit    = (TIMEOUT_CYC != 0) && (timer == TO_LAST);
    assign to_err    = wd_state && !evt && wd_hit;
    assign loop_next = (loop_cnt == LOOP_MAX) ? loop_cnt : loop_cnt + 1'b1;
    assign sq.phase  = state;

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            state            <= S_IDLE;
            timer            <= '0;
            last_bus         <= '0;
            loops            <= '0;
            loop_cnt         <= '0;
            sq.osc_auto_trim <= 1'b0;
            sq.test_rx       <= 1'b0;
            sq.test_tx       <= 1'b0;
            sq.test_advanced <= 1'b0;
            sq.endwait_all   <= 1'b0;
            sq.bus_sel       <= '0;
            sq.done          <= 1'b0;
            sq.err_timeout   <= 1'b0;
        end else begin
            sq.endwait_all <= 1'b0;
            if (evt || !(wd_state || state == S_GAP))
                timer <= '0;
            else
                timer <= timer + 1'b1;

            case (state)
                S_IDLE: if (sq.start) begin
                    state            <= sq.trim_en ? S_TRIM : S_WAIT_SIGNON;
                    sq.osc_auto_trim <= sq.trim_en;
                    last_bus         <= BUS_W'(nb_clamp - 1'b1);
                    loops            <= sq.tx_loop_count;
                    sq.bus_sel       <= '0;
                end
                S_TRIM: if (evt) begin
                    state            <= S_WAIT_SIGNON;
                    sq.osc_auto_trim <= 1'b0;
                end
                S_WAIT_SIGNON: if (evt) begin
                    state      <= S_RX_RUN;
                    sq.test_rx <= 1'b1;
                    sq.bus_sel <= '0;
                end
                S_RX_RUN: if (evt) begin
                    // Dropping test_rx for a cycle marks the bus change to the environment.
                    sq.test_rx <= 1'b0;
                    if (sq.bus_sel != last_bus) begin
                        sq.bus_sel <= sq.bus_sel + 1'b1;
                    end else begin
                        state          <= S_ENDWAIT;
                        sq.endwait_all <= 1'b1;
                    end
                end else begin
                    sq.test_rx <= 1'b1;
                end
                S_ENDWAIT: state <= S_GAP;
                S_GAP: if (timer == GAP_LAST) begin
                    state      <= S_TX_RUN;
                    timer      <= '0;
                    sq.test_tx <= 1'b1;
                    sq.bus_sel <= '0;
                    loop_cnt   <= '0;
                end
                S_TX_RUN: if (evt) begin
                    loop_cnt <= loop_next;
                    if (loops != '0 && loop_next == loops) begin
                        sq.test_tx <= 1'b0;
                        if (sq.adv_en) begin
                            state            <= S_ADV_RUN;
                            sq.test_advanced <= 1'b1;
                        end else begin
                            state   <= S_DONE;
                            sq.done <= 1'b1;
                        end
                    end
                end
                S_ADV_RUN: if (evt) begin
                    state            <= S_DONE;
                    sq.test_advanced <= 1'b0;
                    sq.done          <= 1'b1;
                end
                S_DONE: if (!sq.start) begin
                    state      <= S_IDLE;
                    sq.done    <= 1'b0;
                    sq.bus_sel <= '0;
                end
                S_ERR: if (!sq.start) begin
                    state          <= S_IDLE;
                    sq.err_timeout <= 1'b0;
                    sq.bus_sel     <= '0;
                end
                default: state <= S_IDLE;
            endcase

            if (to_err) begin
                state            <= S_ERR;
                sq.err_timeout   <= 1'b1;
                sq.osc_auto_trim <= 1'b0;
                sq.test_rx       <= 1'b0;
                sq.test_tx       <= 1'b0;
                sq.test_advanced <= 1'b0;
            end
        end
    end

`ifdef MOPSHUB_SEQ_STATS_EN
    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            rx_done_cnt <= '0;
            tx_done_cnt <= '0;
            timeout_cnt <= '0;
        end else begin
            if (state == S_RX_RUN && evt && rx_done_cnt != '1)
                rx_done_cnt <= rx_done_cnt + 1'b1;
            if (state == S_TX_RUN && evt && tx_done_cnt != '1)
                tx_done_cnt <= tx_done_cnt + 1'b1;
            if (to_err && timeout_cnt != '1)
                timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// Self-checking bench for mopshub_test_sequencer: scenario table, hand-written corner sequences,
// and randomized runs checked against an event-count model of the phase sequence.
`timescale 1ns/100ps
module tb_mopshub_test_sequencer;
    localparam int N_BUS       = 16;
    localparam int BUS_W       = 5;
    localparam int GAP_CYC     = 120;
    localparam int LOOP_W      = 8;
    localparam int TIMEOUT_CYC = 100;

    localparam int P_IDLE = 0, P_TRIM = 1, P_SIGNON = 2, P_RX = 3, P_ENDWAIT = 4;
    localparam int P_GAP = 5, P_TX = 6, P_ADV = 7, P_DONE = 8, P_ERR = 9;

    logic clk_40_m = 1'b0;
    logic rst      = 1'b0;
    always #12.5 clk_40_m = ~clk_40_m;

    mopshub_test_sequencer_if #(.BUS_W(BUS_W), .LOOP_W(LOOP_W)) sq();

`ifdef MOPSHUB_SEQ_STATS_EN
    logic [15:0] rx_done_cnt;
    logic [15:0] tx_done_cnt;
    logic [7:0]  timeout_cnt;
`endif

    mopshub_test_sequencer #(
        .N_BUS(N_BUS), .BUS_W(BUS_W), .GAP_CYC(GAP_CYC),
        .LOOP_W(LOOP_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_40_m(clk_40_m),
        .rst(rst),
`ifdef MOPSHUB_SEQ_STATS_EN
        .rx_done_cnt(rx_done_cnt),
        .tx_done_cnt(tx_done_cnt),
        .timeout_cnt(timeout_cnt),
`endif
        .sq(sq)
    );

    // One run scenario: inputs, driver pacing, and expected outcome.
    typedef struct {
        int trim;
        int adv;
        int nb;
        int loops;
        int dly;
        int stall;      // index of the completion event the driver withholds (-1: none)
        int exp_buses;
        int exp_tx;
        int exp_phase;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_40_m);
        #1;
    endtask

    task automatic set_end(input int which, input logic v);
        case (which)
            P_TRIM:   sq.end_power_init    = v;
            P_SIGNON: sq.sign_on_sig       = v;
            P_RX:     sq.test_rx_end       = v;
            P_TX:     sq.test_tx_end       = v;
            P_ADV:    sq.test_advanced_end = v;
            default:  ;
        endcase
    endtask

    task automatic pulse(input int which);
        set_end(which, 1'b1);
        tick();
        set_end(which, 1'b0);
    endtask

    function automatic int outs();
        return int'({sq.osc_auto_trim, sq.test_rx, sq.test_tx, sq.test_advanced, sq.endwait_all,
                     sq.bus_sel, sq.phase, sq.done, sq.err_timeout});
    endfunction

    function automatic int eff_buses(input int nb);
        return (nb == 0) ? 1 : ((nb > N_BUS) ? N_BUS : nb);
    endfunction

    function automatic int clampi(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    // Event list: [trim] signon rx*eff tx*loops [adv]; a withheld event ends the run in ERR.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int eff, pre, total;
        r     = v;
        eff   = eff_buses(v.nb);
        pre   = v.trim + 1;
        total = pre + eff + v.loops + v.adv;
        if (v.stall < 0 || v.stall >= total) begin
            r.exp_buses = eff;
            r.exp_tx    = v.loops;
            r.exp_phase = P_DONE;
        end else begin
            r.exp_buses = clampi(v.stall - pre, 0, eff);
            r.exp_tx    = clampi(v.stall - pre - eff, 0, v.loops);
            r.exp_phase = P_ERR;
        end
        return r;
    endfunction

    // Reactive driver: answers each handshake phase with its *_end pulse after v.dly cycles.
    task automatic play(input vec_t v, input string tag);
        int  k = 0, wcnt = 0, since = 0, rx_n = 0, tx_n = 0, drops = 0;
        int  ew_n = 0, ew_cyc = -1, gap = -1, fin_ph = -1;
        int  ph, prev_ph, which, eff;
        bit  tx_seen = 0;
        eff              = eff_buses(v.nb);
        sq.trim_en       = v.trim[0];
        sq.adv_en        = v.adv[0];
        sq.n_buses       = BUS_W'(v.nb);
        sq.tx_loop_count = LOOP_W'(v.loops);
        sq.start         = 1'b1;
        prev_ph          = int'(sq.phase);
        for (int cyc = 0; cyc < 4000 && fin_ph < 0; cyc++) begin
            which = -1;
            ph    = int'(sq.phase);
            if (k != v.stall && (ph == P_TRIM || ph == P_SIGNON || ph == P_RX ||
                                 ph == P_TX || ph == P_ADV)) begin
                if (wcnt >= v.dly) begin
                    which = ph;
                    if (ph == P_RX) begin
                        check({tag, " bus_sel"}, int'(sq.bus_sel), rx_n);
                        rx_n++;
                    end
                    if (ph == P_TX) tx_n++;
                    set_end(which, 1'b1);
                    k++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            tick();
            if (which >= 0) set_end(which, 1'b0);
            ph = int'(sq.phase);
            if (sq.endwait_all) begin
                ew_n++;
                ew_cyc = cyc;
            end
            if (ph == P_RX && !sq.test_rx) drops++;
            if (sq.test_tx && !tx_seen) begin
                tx_seen = 1;
                if (ew_cyc >= 0) gap = cyc - ew_cyc - 1;
            end
            if (ph == P_ERR) begin
                fin_ph = ph;
                check({tag, " timeout_cycles"}, since + 1, TIMEOUT_CYC);
                check({tag, " err_timeout"}, int'(sq.err_timeout), 1);
                check({tag, " test_lvls_in_err"},
                      int'({sq.test_rx, sq.test_tx, sq.test_advanced}), 0);
            end else if (ph == P_DONE) begin
                fin_ph = ph;
                check({tag, " done"}, int'(sq.done), 1);
            end else if (which >= 0 || ph != prev_ph) begin
                since = 0;
            end else begin
                since++;
            end
            if (ph != prev_ph) wcnt = 0;
            prev_ph = ph;
        end
        if (fin_ph < 0) check({tag, " run_budget"}, 0, 1);
        check({tag, " final_phase"}, fin_ph, v.exp_phase);
        check({tag, " rx_count"}, rx_n, v.exp_buses);
        check({tag, " tx_count"}, tx_n, v.exp_tx);
        check({tag, " rx_drops"}, drops, (v.exp_buses < eff - 1) ? v.exp_buses : eff - 1);
        if (v.exp_buses == eff) begin
            check({tag, " endwait_pulses"}, ew_n, 1);
            check({tag, " gap_cycles"}, gap, GAP_CYC);
        end else begin
            check({tag, " endwait_pulses"}, ew_n, 0);
        end
        sq.start = 1'b0;
        tick();
        check({tag, " back_to_idle"}, int'(sq.phase), P_IDLE);
        check({tag, " idle_done"}, int'(sq.done), 0);
    endtask

    vec_t tbl[9];

    initial begin
        vec_t v;
        int   osc_hi;

        //        trim adv nb loops dly stall | buses tx phase
        tbl[0] = '{1, 1,  3, 4, 50, -1,  3, 4, P_DONE};
        tbl[1] = '{0, 0,  0, 2, 10, -1,  1, 2, P_DONE};
        tbl[2] = '{0, 0, 31, 1,  5, -1, 16, 1, P_DONE};
        tbl[3] = '{0, 1, 16, 2,  3, -1, 16, 2, P_DONE};
        tbl[4] = '{1, 0,  2, 3,  7,  0,  0, 0, P_ERR};
        tbl[5] = '{0, 0,  4, 2,  8,  3,  2, 0, P_ERR};
        tbl[6] = '{0, 1,  1, 0,  6,  8,  1, 6, P_ERR};
        tbl[7] = '{0, 1,  1, 2,  6,  4,  1, 2, P_ERR};
        tbl[8] = '{1, 0,  5, 1, 20,  1,  0, 0, P_ERR};

        sq.start = 1'b0; sq.trim_en = 1'b0; sq.adv_en = 1'b0;
        sq.n_buses = '0; sq.tx_loop_count = '0;
        sq.end_power_init = 1'b0; sq.sign_on_sig = 1'b0;
        sq.test_rx_end = 1'b0; sq.test_tx_end = 1'b0; sq.test_advanced_end = 1'b0;

        rst = 1'b0;
        tick(2);
        check("reset_outputs", outs(), 0);
        rst = 1'b1;

        // Trim: request held for cycles 1..20, end_power_init sampled at cycle 21.
        sq.trim_en = 1'b1; sq.adv_en = 1'b1; sq.n_buses = 5'd3; sq.tx_loop_count = 8'd4;
        sq.start = 1'b1;
        check("osc_before_start", int'(sq.osc_auto_trim), 0);
        osc_hi = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (sq.osc_auto_trim) osc_hi++;
        end
        check("osc_high_cycles", osc_hi, 20);
        sq.n_buses = 5'd9;   // post-start input changes must not matter
        pulse(P_TRIM);
        check("osc_after_init", int'(sq.osc_auto_trim), 0);
        check("phase_after_trim", int'(sq.phase), P_SIGNON);

        // Spurious ends and a start=0 blip outside their phases are ignored.
        pulse(P_RX); pulse(P_TX); pulse(P_ADV);
        sq.start = 1'b0; tick(); sq.start = 1'b1;
        check("spurious_ignored", int'(sq.phase), P_SIGNON);

        pulse(P_SIGNON);
        check("rx_entry_phase", int'(sq.phase), P_RX);
        check("rx_entry_level", int'(sq.test_rx), 1);
        // test_rx_end lands on the timeout cycle: completion wins.
        tick(TIMEOUT_CYC - 1);
        check("no_early_timeout", int'(sq.phase), P_RX);
        pulse(P_RX);
        check("coincide_phase", int'(sq.phase), P_RX);
        check("coincide_bus_sel", int'(sq.bus_sel), 1);
        check("coincide_no_err", int'(sq.err_timeout), 0);
        check("rx_drop", int'(sq.test_rx), 0);
        tick();
        check("rx_reassert", int'(sq.test_rx), 1);
        pulse(P_RX);
        check("bus_sel_2", int'(sq.bus_sel), 2);
        tick();
        pulse(P_RX);
        check("endwait_phase", int'(sq.phase), P_ENDWAIT);
        check("endwait_high", int'(sq.endwait_all), 1);
        tick();
        check("gap_phase", int'(sq.phase), P_GAP);
        check("endwait_one_cycle", int'(sq.endwait_all), 0);
        tick(10);
        rst = 1'b0; sq.start = 1'b0;
        tick();
        check("reset_mid_gap", outs(), 0);
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) play(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 12; i++) begin
            int total;
            v.trim  = int'($urandom_range(0, 1));
            v.adv   = int'($urandom_range(0, 1));
            v.nb    = int'($urandom_range(0, 31));
            v.loops = int'($urandom_range(1, 5));
            v.dly   = int'($urandom_range(1, 60));
            total   = v.trim + 1 + eff_buses(v.nb) + v.loops + v.adv;
            v.stall = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, total - 1));
            v.exp_buses = 0; v.exp_tx = 0; v.exp_phase = 0;
            play(model(v), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
